block_field: RTL and testbench

Owns the 15-block brick wall: stores which blocks are alive, detects overlap between the ball box and each alive block, and removes the struck block. Sits directly upstream of the ball controller, driving its per-block collision pulses, the struck block's geometry and the win flag. Also produces the wall's pixel colour for the VGA compositor.

---
 rtl/block_field_if.sv | 41 ++++
 rtl/block_field.sv | 206 ++++++++++++++++++++
 tb/tb_block_field.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/block_field_if.sv
// block_field_if: groups the pixel scan, ball box, game flags and the wall's
// outputs (hit pulses, struck-block geometry, score, win, colour).
// The observation signals dbg_state and dbg_alive expose the FSM state and the
// alive mask so checkers can bind to them.
// Handshake: there is no valid/ready pair. Each bit of collide is a one-cycle
// valid strobe, and no ready is involved. block_x, block_y and score are
// meaningful in the same cycle as the strobe and are held until the next hit.
interface block_field_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active_pixels;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [9:0]  ball_width;
  logic [9:0]  ball_height;
  logic        lose;
  logic [14:0] collide;
  logic [9:0]  block_x;
  logic [9:0]  block_y;
  logic [9:0]  block_width;
  logic [9:0]  block_height;
  logic [3:0]  score;
  logic        win;
  logic [23:0] vga_color;
  logic        dbg_state;
  logic [14:0] dbg_alive;

  // The block_field side.
  modport slave (
    input  x, y, active_pixels, ball_x, ball_y, ball_width, ball_height, lose,
    output collide, block_x, block_y, block_width, block_height, score, win,
           vga_color, dbg_state, dbg_alive
  );

  // The driver side (ball controller / compositor / bench).
  modport master (
    output x, y, active_pixels, ball_x, ball_y, ball_width, ball_height, lose,
    input  collide, block_x, block_y, block_width, block_height, score, win,
           vga_color, dbg_state, dbg_alive
  );
endinterface

// File: rtl/block_field.sv
// block_field: a 15-block brick wall (3 rows x 5 columns, each block 120x40).
// It tracks the alive blocks, takes one hit per ball contact, keeps the score
// and the win flag, and produces the wall's pixel colour.
// Optional feature macro: BLOCK_FIELD_TWO_HIT_EN. When it is defined, each
// row-0 block cracks on its first hit and is destroyed on its second.
module block_field (
  input  logic          clk,
  input  logic          rst,
  block_field_if.slave  bus
);

  typedef enum logic {ST_SCAN = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [10:0] BLK_W = 11'd120;
  localparam logic [10:0] BLK_H = 11'd40;

  // Left edge of block idx. idx = 5*row + col.
  function automatic logic [10:0] f_bx(input logic [3:0] idx);
    logic [10:0] v;
    case (idx)
      4'd0, 4'd5, 4'd10: v = 11'd10;
      4'd1, 4'd6, 4'd11: v = 11'd135;
      4'd2, 4'd7, 4'd12: v = 11'd260;
      4'd3, 4'd8, 4'd13: v = 11'd385;
      4'd4, 4'd9, 4'd14: v = 11'd510;
      default:           v = 11'd0;
    endcase
    return v;
  endfunction

  // Top edge of block idx.
  function automatic logic [10:0] f_by(input logic [3:0] idx);
    logic [10:0] v;
    if (idx < 4'd5)       v = 11'd40;
    else if (idx < 4'd10) v = 11'd90;
    else                  v = 11'd140;
    return v;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [14:0] r_alive;
  logic [14:0] r_collide;
  logic [9:0]  r_block_x;
  logic [9:0]  r_block_y;
  logic [3:0]  r_score;
  logic        r_win;
  logic [3:0]  r_hit_idx;

  logic [10:0] w_ball_l;
  logic [10:0] w_ball_r;
  logic [10:0] w_ball_t;
  logic [10:0] w_ball_b;
  logic [14:0] w_overlap;
  logic [14:0] w_cand;
  logic        w_any;
  logic [3:0]  w_first;
  logic        w_hold_ov;
  logic        w_take_hit;
  logic        w_crack_only;
  logic [10:0] w_hit_bx;
  logic [10:0] w_hit_by;
  logic [23:0] w_color;

`ifdef BLOCK_FIELD_TWO_HIT_EN
  logic [4:0]  r_cracked;
`endif

  // Box overlap of the ball against every block rectangle, ignoring alive.
  // All sums are 11 bits wide so that they cannot wrap.
  always_comb begin
    w_ball_l = {1'b0, bus.ball_x};
    w_ball_t = {1'b0, bus.ball_y};
    w_ball_r = {1'b0, bus.ball_x} + {1'b0, bus.ball_width};
    w_ball_b = {1'b0, bus.ball_y} + {1'b0, bus.ball_height};
    w_overlap = '0;
    for (int i = 0; i < 15; i++) begin
      w_overlap[i] = (w_ball_l < f_bx(4'(i)) + BLK_W) &&
                     (w_ball_r > f_bx(4'(i))) &&
                     (w_ball_t < f_by(4'(i)) + BLK_H) &&
                     (w_ball_b > f_by(4'(i)));
    end
  end

  // Lowest-index alive overlapping block wins when several are touched.
  always_comb begin
    w_cand  = w_overlap & r_alive;
    w_any   = 1'b0;
    w_first = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_any   = 1'b1;
        w_first = 4'(i);
      end
    end
  end

  // Geometry of the block being hit, and whether this hit only cracks it.
  always_comb begin
    w_hit_bx     = f_bx(w_first);
    w_hit_by     = f_by(w_first);
    w_crack_only = 1'b0;
`ifdef BLOCK_FIELD_TWO_HIT_EN
    if (w_first < 4'd5) begin
      w_crack_only = !r_cracked[w_first[2:0]];
    end
`endif
  end

  // HOLD exits on the struck rectangle alone, so a block that has just died
  // still holds the FSM until the ball leaves it.
  assign w_hold_ov = w_overlap[r_hit_idx];

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_SCAN;
    else      r_state <= w_state_nxt;
  end

  // FSM next state and hit acceptance. A hit is taken only from SCAN with the
  // game still running.
  always_comb begin
    w_state_nxt = r_state;
    w_take_hit  = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (!bus.lose && !r_win && w_any) begin
          w_take_hit  = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!w_hold_ov) w_state_nxt = ST_SCAN;
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  // Wall state: the hit pulse, the struck-block latch, alive, score and win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_collide <= '0;
      r_block_x <= '0;
      r_block_y <= '0;
      r_alive   <= 15'h7fff;
      r_score   <= '0;
      r_win     <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      r_collide <= '0;
      if (w_take_hit) begin
        r_collide <= 15'd1 << w_first;
        r_block_x <= w_hit_bx[9:0];
        r_block_y <= w_hit_by[9:0];
        r_hit_idx <= w_first;
        if (!w_crack_only) begin
          r_alive[w_first] <= 1'b0;
          r_score          <= r_score + 4'd1;
        end
      end
      if (r_alive == 15'd0) r_win <= 1'b1;
    end
  end

`ifdef BLOCK_FIELD_TWO_HIT_EN
  // Crack marks for row 0. Set on the first hit of an uncracked block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cracked <= '0;
    end else if (w_take_hit && w_crack_only) begin
      r_cracked[w_first[2:0]] <= 1'b1;
    end
  end
`endif

  // Wall colour for the current pixel. It is combinational in x, y and alive.
  always_comb begin
    w_color = 24'h000000;
    if (bus.active_pixels) begin
      for (int i = 0; i < 15; i++) begin
        if (r_alive[i] &&
            ({1'b0, bus.x} >= f_bx(4'(i))) && ({1'b0, bus.x} < f_bx(4'(i)) + BLK_W) &&
            ({1'b0, bus.y} >= f_by(4'(i))) && ({1'b0, bus.y} < f_by(4'(i)) + BLK_H)) begin
          if (i < 5)       w_color = 24'hff0000;
          else if (i < 10) w_color = 24'h00ff00;
          else             w_color = 24'h0000ff;
`ifdef BLOCK_FIELD_TWO_HIT_EN
          if (i < 5 && r_cracked[i]) w_color = 24'h808080;
`endif
        end
      end
    end
  end

  assign bus.collide      = r_collide;
  assign bus.block_x      = r_block_x;
  assign bus.block_y      = r_block_y;
  assign bus.block_width  = 10'd120;
  assign bus.block_height = 10'd40;
  assign bus.score        = r_score;
  assign bus.win          = r_win;
  assign bus.vga_color    = w_color;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_alive    = r_alive;

endmodule

// File: tb/tb_block_field.sv
// tb_block_field: directed bench for block_field in its default build
// (BLOCK_FIELD_TWO_HIT_EN undefined). The stimulus pushes each expected hit
// into exp_q. A monitor pops one entry for every collide pulse it sees.
module tb_block_field;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [38:0] exp_q[$];   // {collide[14:0], block_x[9:0], block_y[9:0], score[3:0]}

  block_field_if bus();

  block_field dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance n clocks; return 1 ns after the last edge
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ball(input int bx, input int by, input int bw, input int bh);
    bus.ball_x      = 10'(bx);
    bus.ball_y      = 10'(by);
    bus.ball_width  = 10'(bw);
    bus.ball_height = 10'(bh);
  endtask

  task automatic ball_away();
    set_ball(0, 0, 1, 1);
  endtask

  task automatic push_exp(input int idx, input int ebx, input int eby, input int esc);
    logic [14:0] c;
    logic [38:0] e;
    c = 15'd1 << idx;
    e = {c, 10'(ebx), 10'(eby), 4'(esc)};
    exp_q.push_back(e);
  endtask

  function automatic int col_x(input int idx);
    int t[5];
    t = '{10, 135, 260, 385, 510};
    return t[idx % 5];
  endfunction

  function automatic int row_y(input int idx);
    int t[3];
    t = '{40, 90, 140};
    return t[idx / 5];
  endfunction

  // Strike block idx at its centre and check the one-edge latency.
  // Call this 1 ns after an edge.
  task automatic strike(input int idx, input int esc);
    push_exp(idx, col_x(idx), row_y(idx), esc);
    set_ball(col_x(idx) + 50, row_y(idx) + 15, 10, 10);
    wait_cyc(1);
    check($sformatf("latency_blk%0d", idx), 32'(bus.collide), 32'(15'd1 << idx));
  endtask

  // monitor / scoreboard
  initial begin
    logic [38:0] e;
    forever begin
      @(negedge clk);
      if (rst && bus.collide != 15'd0) begin
        check("mon_onehot", 32'($onehot(bus.collide)), 32'd1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mon_unexpected: got collide %0h expected no pulse", bus.collide);
        end else begin
          e = exp_q.pop_front();
          check("mon_collide", 32'(bus.collide), 32'(e[38:24]));
          check("mon_block_x", 32'(bus.block_x), 32'(e[23:14]));
          check("mon_block_y", 32'(bus.block_y), 32'(e[13:4]));
          check("mon_score",   32'(bus.score),   32'(e[3:0]));
        end
      end
    end
  end

  // stimulus
  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.active_pixels = 1'b0;
    bus.lose = 1'b0;
    ball_away();
    wait_cyc(3);
    check("rst_alive",   32'(bus.dbg_alive), 32'h7fff);
    rst = 1'b1;
    wait_cyc(1);
    check("rst_collide", 32'(bus.collide), 32'h0);
    check("rst_block_x", 32'(bus.block_x), 32'd0);
    check("rst_block_y", 32'(bus.block_y), 32'd0);
    check("rst_score",   32'(bus.score), 32'd0);
    check("rst_win",     32'(bus.win), 32'd0);
    check("rst_state",   32'(bus.dbg_state), 32'd0);
    check("const_w",     32'(bus.block_width), 32'd120);
    check("const_h",     32'(bus.block_height), 32'd40);

    // single hit on block 1, held for 100 clocks
    push_exp(1, 135, 40, 1);
    set_ball(140, 60, 20, 20);
    wait_cyc(1);
    check("b1_pulse", 32'(bus.collide), 32'h0002);
    wait_cyc(99);
    check("b1_alive", 32'(bus.dbg_alive), 32'h7ffd);
    check("b1_hold",  32'(bus.dbg_state), 32'd1);
    ball_away();
    wait_cyc(3);
    check("b1_scan", 32'(bus.dbg_state), 32'd0);
    set_ball(140, 60, 20, 20);     // the dead block must not pulse
    wait_cyc(10);
    check("b1_dead_scan", 32'(bus.dbg_state), 32'd0);
    check("b1_score", 32'(bus.score), 32'd1);
    ball_away();
    wait_cyc(3);

    // straddle blocks 6 and 7: only 6 pulses
    push_exp(6, 135, 90, 2);
    set_ball(250, 100, 20, 20);
    wait_cyc(1);
    check("b6_pulse", 32'(bus.collide), 32'h0040);
    wait_cyc(10);
    check("b6_hold", 32'(bus.dbg_state), 32'd1);
    ball_away();
    wait_cyc(3);
    push_exp(7, 260, 90, 3);
    set_ball(300, 100, 20, 20);
    wait_cyc(1);
    check("b7_pulse", 32'(bus.collide), 32'h0080);
    ball_away();
    wait_cyc(3);

    // lose freezes hits
    bus.lose = 1'b1;
    set_ball(20, 50, 10, 10);
    wait_cyc(10);
    check("lose_score", 32'(bus.score), 32'd3);
    check("lose_alive", 32'(bus.dbg_alive), 32'h7f3d);
    check("lose_state", 32'(bus.dbg_state), 32'd0);
    ball_away();
    wait_cyc(2);
    bus.lose = 1'b0;
    wait_cyc(2);

    // colour
    bus.active_pixels = 1'b1;
    bus.x = 10'd20;  bus.y = 10'd50;  #1; check("vga_row0", 32'(bus.vga_color), 32'hff0000);
    bus.x = 10'd140; bus.y = 10'd50;  #1; check("vga_dead1", 32'(bus.vga_color), 32'h000000);
    bus.x = 10'd20;  bus.y = 10'd100; #1; check("vga_row1", 32'(bus.vga_color), 32'h00ff00);
    bus.x = 10'd20;  bus.y = 10'd150; #1; check("vga_row2", 32'(bus.vga_color), 32'h0000ff);
    bus.x = 10'd132; bus.y = 10'd50;  #1; check("vga_gap", 32'(bus.vga_color), 32'h000000);
    bus.x = 10'd129; bus.y = 10'd79;  #1; check("vga_corner_in", 32'(bus.vga_color), 32'hff0000);
    bus.x = 10'd130; bus.y = 10'd50;  #1; check("vga_edge_out", 32'(bus.vga_color), 32'h000000);
    bus.x = 10'd20;  bus.y = 10'd50;  bus.active_pixels = 1'b0;
    #1; check("vga_blank", 32'(bus.vga_color), 32'h000000);
    bus.active_pixels = 1'b1;
    wait_cyc(1);

    // destroy block 0, then reset while in HOLD
    strike(0, 4);
    check("vga_b0_dead", 32'(bus.vga_color), 32'h000000);
    wait_cyc(1);
    check("pre_rst_hold", 32'(bus.dbg_state), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_alive", 32'(bus.dbg_alive), 32'h7fff);
    check("mid_rst_score", 32'(bus.score), 32'd0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'd0);
    check("mid_rst_bx",    32'(bus.block_x), 32'd0);
    check("vga_b0_back",   32'(bus.vga_color), 32'hff0000);
    ball_away();
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(2);

    // clear the whole wall
    for (int i = 0; i < 15; i++) begin
      strike(i, i + 1);
      if (i == 14) begin
        check("win_not_yet", 32'(bus.win), 32'd0);
        wait_cyc(1);
        check("win_rise", 32'(bus.win), 32'd1);
      end else begin
        check("win_low", 32'(bus.win), 32'd0);
      end
      ball_away();
      wait_cyc(3);
    end
    check("final_score", 32'(bus.score), 32'd15);
    check("final_alive", 32'(bus.dbg_alive), 32'h0000);
    set_ball(20, 50, 10, 10);
    wait_cyc(5);
    check("win_scan", 32'(bus.dbg_state), 32'd0);
    check("win_sticky", 32'(bus.win), 32'd1);
    ball_away();
    wait_cyc(3);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL exp_q_drain: got %0d pending hits expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
